i2c_led_btn_arb: RTL
====================

Name: i2c_led_btn_arb

Overview:
- Shares the two open-drain board pins, SCL/LED_n and SDA/BTN_n, between three users: an I2C master (the SGTL5000 init sequencer and any later codec control), the user LED, and the user button.
- Outside I2C transactions, it lights the LED by holding SCL low. It periodically releases the pins briefly to sample and debounce the button on SDA.
- It grants exclusive pin access to the I2C master on request, with guard time on both sides of the grant.
- It sits between the codec/boot control logic and the pad wrapper. Pad primitives (SB_IO) stay in the wrapper.

Parameters:
- SAMPLE_PERIOD, 24000: cycles between button samples (1 ms at 24 MHz).
- SETTLE, 48: cycles both pins stay released before SDA is sampled.
- GUARD, 24: cycles both pins stay released before a grant and after it ends.
- DEBOUNCE, 8: number of consecutive equal samples needed to change the debounced button state.

Ports:
- clk, in, 1: system clock (clk_24 domain).
- rst_n, in, 1: asynchronous active-low reset.
- i2c_req, in, 1: I2C master requests the pins; held high for the whole transaction.
- i2c_gnt, out, 1: pins are owned by the I2C master.
- i2c_scl_oe, in, 1: master drives SCL low (honoured only while i2c_gnt=1).
- i2c_sda_oe, in, 1: master drives SDA low (honoured only while i2c_gnt=1).
- i2c_sda_i, out, 1: SDA pad value passed to the master (forced 1 while i2c_gnt=0).
- led, in, 1: requested LED state (1 = on).
- btn, out, 1: debounced button state (1 = pressed).
- btn_press, out, 1: one-cycle pulse on a debounced 0->1 transition.
- pad_scl_oe, out, 1: drive SCL pad low.
- pad_sda_oe, out, 1: drive SDA pad low.
- pad_sda_i, in, 1: SDA pad input, already synchronised by the wrapper.

Behaviour:
- Reset values: state=RELEASE, i2c_gnt=0, btn=0, btn_press=0, pad_scl_oe=0, pad_sda_oe=0, period timer=0, debounce counter=0.
- States:
  - LED: pad_scl_oe=led, pad_sda_oe=0. The period timer counts up.
  - SETTLE: both pads released for SETTLE cycles. On the last cycle, ~pad_sda_i is taken as the sample.
  - PRE_GUARD: both pads released for GUARD cycles.
  - GRANT: pad_*_oe = i2c_*_oe; i2c_gnt=1.
  - RELEASE: both pads released for GUARD cycles (also the post-reset state).
- Transitions:
  - LED -> PRE_GUARD when i2c_req=1. This takes priority over a sample becoming due in the same cycle; the period timer holds its value.
  - LED -> SETTLE when the timer reaches SAMPLE_PERIOD-1 and i2c_req=0. The timer clears.
  - SETTLE -> LED after the sample. A request arriving during SETTLE is deferred until the sample completes; SETTLE is never aborted.
  - PRE_GUARD -> GRANT after GUARD cycles. If i2c_req drops during PRE_GUARD, go to RELEASE.
  - GRANT -> RELEASE in the cycle after i2c_req=0. i2c_gnt falls registered, 1 cycle after req falls.
  - RELEASE -> LED after GUARD cycles. A new request during RELEASE waits for RELEASE to finish, then goes LED -> PRE_GUARD.
- Grant latency from req rise, when in LED: GUARD+1 cycles. All outputs are registered.
- Debounce:
  - A sample differing from btn increments the counter; a sample equal to btn clears it.
  - When the counter reaches DEBOUNCE-1 and another differing sample arrives, btn toggles and the counter clears.
  - btn_press pulses 1 cycle on 0->1.
  - No samples are taken in GRANT, PRE_GUARD or RELEASE. btn and the counter hold.
- The period timer holds during PRE_GUARD, GRANT and RELEASE, and resumes afterwards.
- Counter widths are $clog2(max+1). Counters saturate and never wrap.
- Asynchronous reset mid-transaction: pads release immediately and i2c_gnt=0. The master is responsible for restarting its transaction.
- The LED is never driven while i2c_gnt=1. The LED change from a led edge appears on pad_scl_oe 1 cycle later, in LED state only.

Decomposition:
- Package sid (or a board package): enum arb_state_t {LED, SETTLE, PRE_GUARD, GRANT, RELEASE}; default timing localparams.
- One natural sub-module: btn_debounce, containing the counter, btn and btn_press, with a sample_valid/sample input. Everything else stays in the arbiter.

Test Plan (SAMPLE_PERIOD=20, SETTLE=4, GUARD=2, DEBOUNCE=3):
- Reset then idle, led=1: RELEASE lasts 2 cycles, then pad_scl_oe=1. Every 20 cycles, pad_scl_oe=0 for exactly 4 cycles; pad_sda_oe stays 0 throughout.
- pad_sda_i=0 held: btn rises after the 3rd sample, btn_press=1 for 1 cycle. Pad low for 2 samples then high for 1: btn stays 0.
- i2c_req rises in LED: i2c_gnt=1 at req+3. Pads mirror i2c_scl_oe/i2c_sda_oe, and i2c_sda_i follows pad_sda_i. req falls: gnt=0 next cycle, pads released 2 cycles, then LED resumes.
- i2c_req rises in the 2nd SETTLE cycle: the sample completes, then PRE_GUARD, then grant. The sample is counted exactly once.
- Button pressed during a grant: btn unchanged during the grant. After LED resumes, 3 samples later btn=1.
- rst_n asserted during GRANT with i2c_scl_oe=1: pad_scl_oe=0 and i2c_gnt=0 in the same cycle (asynchronous), then RELEASE after rst_n rises.

Source files
------------

// File: rtl/i2c_led_btn_arb_pkg.sv
// Shared types and default timing for the SCL/LED_n + SDA/BTN_n pin arbiter.
// Defaults assume clk_24 (24 MHz).
package i2c_led_btn_arb_pkg;

    typedef enum logic [2:0] {
        ST_LED,
        ST_SETTLE,
        ST_PRE_GUARD,
        ST_GRANT,
        ST_RELEASE
    } arb_state_t;

    localparam int DEF_SAMPLE_PERIOD = 24000;
    localparam int DEF_SETTLE        = 48;
    localparam int DEF_GUARD         = 24;
    localparam int DEF_DEBOUNCE      = 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/i2c_led_btn_arb_btn_debounce.sv
// Button debouncer: the state flips only after DEBOUNCE consecutive samples
// that disagree with it; btn_press marks each debounced press.
module i2c_led_btn_arb_btn_debounce
    import i2c_led_btn_arb_pkg::*;
#(
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_valid,
    input  logic sample,
    output logic btn,
    output logic btn_press
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [CW-1:0] r_cnt;
    logic          r_btn;
    logic          r_press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_btn   <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (sample_valid) begin
                if (sample == r_btn) begin
                    r_cnt <= '0;
                end else if (r_cnt >= CW'(DEBOUNCE - 1)) begin
                    r_btn   <= ~r_btn;
                    r_cnt   <= '0;
                    r_press <= ~r_btn;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign btn       = r_btn;
    assign btn_press = r_press;

endmodule

// File: rtl/i2c_led_btn_arb.sv
// Arbitrates the shared open-drain SCL/LED_n and SDA/BTN_n pins between the
// I2C master, the user LED and periodic button sampling.
module i2c_led_btn_arb
    import i2c_led_btn_arb_pkg::*;
#(
    parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
    parameter int SETTLE        = DEF_SETTLE,
    parameter int GUARD         = DEF_GUARD,
    parameter int DEBOUNCE      = DEF_DEBOUNCE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i2c_req,
    output logic i2c_gnt,
    input  logic i2c_scl_oe,
    input  logic i2c_sda_oe,
    output logic i2c_sda_i,
    input  logic led,
    output logic btn,
    output logic btn_press,
    output logic pad_scl_oe,
    output logic pad_sda_oe,
    input  logic pad_sda_i
);

    localparam int TW   = $clog2(SAMPLE_PERIOD + 1);
    localparam int SMAX = max2(SETTLE, GUARD);
    localparam int SW   = $clog2(SMAX + 1);

    arb_state_t    r_state, w_next;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic [SW-1:0] r_cnt;
    logic          r_gnt, r_scl_oe, r_sda_oe;
    logic          w_sample_vld;
    logic          w_guard_done, w_settle_done, w_sample_due;

    assign w_guard_done  = (r_cnt == SW'(GUARD - 1));
    assign w_settle_done = (r_cnt == SW'(SETTLE - 1));
    assign w_sample_due  = (r_timer >= TW'(SAMPLE_PERIOD - 1));

    // Timer only advances on LED cycles that neither start a sample nor yield to a request.
    always_comb begin
        w_next       = r_state;
        w_timer_nxt  = r_timer;
        w_sample_vld = 1'b0;
        case (r_state)
            ST_LED: begin
                if (i2c_req) begin
                    w_next = ST_PRE_GUARD;
                end else if (w_sample_due) begin
                    w_next      = ST_SETTLE;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (w_settle_done) begin
                    w_sample_vld = 1'b1;
                    w_next       = ST_LED;
                end
            end
            ST_PRE_GUARD: begin
                if (!i2c_req)          w_next = ST_RELEASE;
                else if (w_guard_done) w_next = ST_GRANT;
            end
            ST_GRANT: begin
                if (!i2c_req) w_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (w_guard_done) w_next = ST_LED;
            end
            default: w_next = ST_RELEASE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RELEASE;
            r_timer <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_timer <= w_timer_nxt;
            if (w_next != r_state)            r_cnt <= '0;
            else if (r_cnt != SW'(SMAX - 1))  r_cnt <= r_cnt + 1'b1;
        end
    end

    // Pad drives are registered from the next state so they track it with no extra lag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt    <= 1'b0;
            r_scl_oe <= 1'b0;
            r_sda_oe <= 1'b0;
        end else begin
            r_gnt    <= (w_next == ST_GRANT);
            r_scl_oe <= (w_next == ST_LED)   ? led :
                        (w_next == ST_GRANT) ? i2c_scl_oe : 1'b0;
            r_sda_oe <= (w_next == ST_GRANT) & i2c_sda_oe;
        end
    end

    i2c_led_btn_arb_btn_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (w_sample_vld),
        .sample       (~pad_sda_i),
        .btn          (btn),
        .btn_press    (btn_press)
    );

    assign i2c_gnt    = r_gnt;
    assign pad_scl_oe = r_scl_oe;
    assign pad_sda_oe = r_sda_oe;
    assign i2c_sda_i  = r_gnt ? pad_sda_i : 1'b1;

endmodule
